// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and receiver FSM encoding.
// The VGA controller uses the same values.
package vga_timing_pkg;

  localparam int H_ACTIVE        = 640;
  localparam int H_SYNC          = 96;
  localparam int H_BP            = 48;
  localparam int H_TOTAL         = 800;
  localparam int V_ACTIVE        = 480;
  localparam int V_SYNC          = 2;
  localparam int V_BP            = 33;
  localparam int V_TOTAL         = 525;
  localparam int H_START         = H_SYNC + H_BP;   // 144
  localparam int V_START         = V_SYNC + V_BP;   // 35
  localparam int SYNC_ACTIVE_LOW = 1;
  localparam int LOCK_FRAMES     = 2;

  localparam int HCNT_W = 11;
  localparam int VCNT_W = 10;
  localparam int GOOD_W = 4;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } rx_state_e;

endpackage

// File: rtl/vga_sync_receiver_if.sv
// Pixel-side bundle of the VGA receiver: incoming sync/colour pins and the
// coordinate-tagged pixel / timing status outputs.
interface vga_sync_receiver_if;
  logic        hsync_in;
  logic        vsync_in;
  logic [3:0]  r_in;
  logic [3:0]  g_in;
  logic [3:0]  b_in;
  logic        pix_valid;
  logic [10:0] h_pos;
  logic [9:0]  v_pos;
  logic [3:0]  r_out;
  logic [3:0]  g_out;
  logic [3:0]  b_out;
  logic [10:0] line_len;
  logic [9:0]  frame_lines;
  logic        locked;
  logic        err_pulse;

  modport master (
    output hsync_in, vsync_in, r_in, g_in, b_in,
    input  pix_valid, h_pos, v_pos, r_out, g_out, b_out,
    input  line_len, frame_lines, locked, err_pulse
  );

  modport slave (
    input  hsync_in, vsync_in, r_in, g_in, b_in,
    output pix_valid, h_pos, v_pos, r_out, g_out, b_out,
    output line_len, frame_lines, locked, err_pulse
  );
endinterface

// File: rtl/vga_sync_edge.sv
// Two-stage sync sampler with polarity normalisation; edge_o flags the cycle
// where stage 2 becomes asserted while the previous stage-2 value was not.
module vga_sync_edge #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_i,
  output logic edge_o
);
  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sync_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign edge_o = (s2_q ^ ACTIVE_LOW) & ~(s3_q ^ ACTIVE_LOW);

endmodule

// File: rtl/vga_sync_receiver.sv
// VGA receive front end: rebuilds pixel coordinates from hsync/vsync, checks
// line/frame timing and tags active pixels once timing is locked.
//   state     | meaning
//   ST_SEARCH | no lock, waiting for a vsync edge to start measuring
//   ST_CHECK  | counting consecutive good frames towards lock
//   ST_LOCKED | timing locked, active pixels flagged valid
module vga_sync_receiver #(
  parameter int H_ACTIVE        = vga_timing_pkg::H_ACTIVE,
  parameter int H_SYNC          = vga_timing_pkg::H_SYNC,
  parameter int H_BP            = vga_timing_pkg::H_BP,
  parameter int H_TOTAL         = vga_timing_pkg::H_TOTAL,
  parameter int V_ACTIVE        = vga_timing_pkg::V_ACTIVE,
  parameter int V_SYNC          = vga_timing_pkg::V_SYNC,
  parameter int V_BP            = vga_timing_pkg::V_BP,
  parameter int V_TOTAL         = vga_timing_pkg::V_TOTAL,
  parameter int SYNC_ACTIVE_LOW = vga_timing_pkg::SYNC_ACTIVE_LOW,
  parameter int LOCK_FRAMES     = vga_timing_pkg::LOCK_FRAMES
) (
  input  logic               clk,
  input  logic               rst_n,
  vga_sync_receiver_if.slave vid
);
  import vga_timing_pkg::*;

  localparam logic [HCNT_W-1:0] H_MAX_C   = '1;
  localparam logic [VCNT_W-1:0] V_MAX_C   = '1;
  localparam logic [HCNT_W-1:0] H_TOT_C   = HCNT_W'(H_TOTAL);
  localparam logic [VCNT_W-1:0] V_TOT_C   = VCNT_W'(V_TOTAL);
  localparam logic [HCNT_W-1:0] H_START_C = HCNT_W'(H_SYNC + H_BP);
  localparam logic [HCNT_W-1:0] H_END_C   = HCNT_W'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [VCNT_W-1:0] V_START_C = VCNT_W'(V_SYNC + V_BP);
  localparam logic [VCNT_W-1:0] V_END_C   = VCNT_W'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [GOOD_W-1:0] LOCK_C    = GOOD_W'(LOCK_FRAMES);

  logic              hs_edge, vs_edge;
  logic [11:0]       rgb1_q, rgb2_q;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d, hlen;
  logic [VCNT_W-1:0] vcnt_q, vcnt_d, vlen;
  logic              bad_line_q, bad_line_d;
  logic              line_bad, timeout, frame_good, in_win, pix_d;
  rx_state_e         state_q, state_d;
  logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
  logic              err_d;

  logic              pix_valid_q, locked_q, err_pulse_q;
  logic [HCNT_W-1:0] h_pos_q, line_len_q;
  logic [VCNT_W-1:0] v_pos_q, frame_lines_q;
  logic [11:0]       rgb_out_q;

  vga_sync_edge #(.ACTIVE_LOW(SYNC_ACTIVE_LOW != 0)) u_hs_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .sync_i (vid.hsync_in),
    .edge_o (hs_edge)
  );

  vga_sync_edge #(.ACTIVE_LOW(SYNC_ACTIVE_LOW != 0)) u_vs_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .sync_i (vid.vsync_in),
    .edge_o (vs_edge)
  );

  // hcnt_d/vcnt_d are the coordinates of the pixel currently in stage 2
  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    hlen   = (hcnt_q == H_MAX_C) ? H_MAX_C : hcnt_q + 1'b1;
    vlen   = (vcnt_q == V_MAX_C) ? V_MAX_C : vcnt_q + 1'b1;
    if (hs_edge)               hcnt_d = '0;
    else if (hcnt_q != H_MAX_C) hcnt_d = hcnt_q + 1'b1;
    if (vs_edge)                           vcnt_d = '0;
    else if (hs_edge && vcnt_q != V_MAX_C) vcnt_d = vcnt_q + 1'b1;
  end

  assign line_bad   = hs_edge && (hlen != H_TOT_C);
  assign timeout    = !hs_edge && (hcnt_q == H_MAX_C - 1'b1);
  assign frame_good = (vlen == V_TOT_C) && !bad_line_q && !line_bad;
  assign bad_line_d = vs_edge ? 1'b0 : (bad_line_q | line_bad);

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    err_d      = 1'b0;
    case (state_q)
      ST_SEARCH: begin
        if (vs_edge) begin
          state_d    = ST_CHECK;
          good_cnt_d = '0;
        end
      end
      ST_CHECK: begin
        if (timeout || (vs_edge && !frame_good)) begin
          state_d = ST_SEARCH;
          err_d   = 1'b1;
        end else if (vs_edge) begin
          if (good_cnt_q + 1'b1 == LOCK_C) state_d = ST_LOCKED;
          else                             good_cnt_d = good_cnt_q + 1'b1;
        end
      end
      ST_LOCKED: begin
        if (timeout || line_bad || (vs_edge && !frame_good)) begin
          state_d = ST_SEARCH;
          err_d   = 1'b1;
        end
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  assign in_win = (hcnt_d >= H_START_C) && (hcnt_d < H_END_C) &&
                  (vcnt_d >= V_START_C) && (vcnt_d < V_END_C);
  // next-state lock so pixels after a violation on the same line drop out
  assign pix_d  = (state_d == ST_LOCKED) && in_win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb1_q        <= '0;
      rgb2_q        <= '0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      bad_line_q    <= 1'b0;
      state_q       <= ST_SEARCH;
      good_cnt_q    <= '0;
      pix_valid_q   <= 1'b0;
      h_pos_q       <= '0;
      v_pos_q       <= '0;
      rgb_out_q     <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      locked_q      <= 1'b0;
      err_pulse_q   <= 1'b0;
    end else begin
      rgb1_q      <= {vid.r_in, vid.g_in, vid.b_in};
      rgb2_q      <= rgb1_q;
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      bad_line_q  <= bad_line_d;
      state_q     <= state_d;
      good_cnt_q  <= good_cnt_d;
      pix_valid_q <= pix_d;
      h_pos_q     <= pix_d ? hcnt_d - H_START_C : '0;
      v_pos_q     <= pix_d ? vcnt_d - V_START_C : '0;
      rgb_out_q   <= pix_d ? rgb2_q : '0;
      if (hs_edge) line_len_q    <= hlen;
      if (vs_edge) frame_lines_q <= vlen;
      locked_q    <= (state_d == ST_LOCKED);
      err_pulse_q <= err_d;
    end
  end

  assign vid.pix_valid   = pix_valid_q;
  assign vid.h_pos       = h_pos_q;
  assign vid.v_pos       = v_pos_q;
  assign vid.r_out       = rgb_out_q[11:8];
  assign vid.g_out       = rgb_out_q[7:4];
  assign vid.b_out       = rgb_out_q[3:0];
  assign vid.line_len    = line_len_q;
  assign vid.frame_lines = frame_lines_q;
  assign vid.locked      = locked_q;
  assign vid.err_pulse   = err_pulse_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver on a shrunken raster (28x12 clocks/lines) so
// each frame is a few hundred cycles; expected pixels go through a queue.
module tb_vga_sync_receiver;

  localparam int HA = 16, HS = 4, HB = 4, HT = 28;
  localparam int VA = 6,  VS = 2, VB = 2, VT = 12;
  localparam int HST = HS + HB, VST = VS + VB;
  localparam int STR_LINE = VST + 2;

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
    logic [11:0] rgb;
    logic [23:0] cyc;
  } pix_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #20 clk = ~clk;

  vga_sync_receiver_if vif();

  vga_sync_receiver #(
    .H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HB), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VB), .V_TOTAL(VT),
    .SYNC_ACTIVE_LOW(1), .LOCK_FRAMES(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vid   (vif)
  );

  pix_t        exp_q[$];
  pix_t        got_pix, exp_pix, last_beat;
  int          checks = 0, errors = 0;
  int unsigned cyc = 0;
  int          err_cnt = 0, valid_cnt = 0;
  int unsigned err_cyc = 0, lock_rise_cyc = 0, last_vs_cyc = 0, str_edge_cyc = 0;
  logic [10:0] err_line_len = '0;
  logic [9:0]  err_frame_lines = '0;
  logic        err_locked = 1'b0;
  logic        locked_prev = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {7'd0, vif.pix_valid, vif.h_pos, vif.v_pos, vif.r_out, vif.g_out, vif.b_out,
            vif.line_len, vif.frame_lines, vif.locked, vif.err_pulse};
  endfunction

  function automatic logic [11:0] colour(input int x, input int y);
    logic [3:0] r, g, b;
    if (x == 0 && y == 0) return 12'hF71;
    if (x == HA - 1 && y == VA - 1) return 12'hF11;
    r = 4'(x) ^ 4'h5;
    g = 4'(y + 1);
    b = 4'(x + y + 3);
    return {r, g, b};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (vif.err_pulse) begin
      err_cnt++;
      err_cyc         = cyc;
      err_line_len    = vif.line_len;
      err_frame_lines = vif.frame_lines;
      err_locked      = vif.locked;
    end
    if (vif.locked && !locked_prev) lock_rise_cyc = cyc;
    locked_prev = vif.locked;
    if (vif.pix_valid) begin
      valid_cnt++;
      got_pix   = {vif.h_pos, vif.v_pos, vif.r_out, vif.g_out, vif.b_out, 24'(cyc)};
      last_beat = got_pix;
      if (exp_q.size() == 0) begin
        check_val("spurious_pix", got_pix, 64'd0);
      end else begin
        exp_pix = exp_q.pop_front();
        check_val("pixel", got_pix, exp_pix);
      end
    end else if (rst_n) begin
      check_val("blank_zero", {vif.h_pos, vif.v_pos, vif.r_out, vif.g_out, vif.b_out}, 64'd0);
    end
  end

  task automatic drive_cycle(input bit hs, input bit vs, input logic [11:0] rgb);
    @(posedge clk);
    #1;
    vif.hsync_in = ~hs;
    vif.vsync_in = ~vs;
    vif.r_in     = rgb[11:8];
    vif.g_in     = rgb[7:4];
    vif.b_in     = rgb[3:0];
  endtask

  // lines first..last-1; lines <= valid_upto expect valid pixels;
  // stops before (stop_line, stop_h) when stop_line >= 0
  task automatic drive_frame(input int first, input int last, input int stretch,
                             input int valid_upto, input int stop_line, input int stop_h);
    for (int ln = first; ln < last; ln++) begin
      int len;
      len = (ln == stretch) ? HT + 1 : HT;
      for (int h = 0; h < len; h++) begin
        bit          act;
        logic [11:0] rgb;
        pix_t        p;
        if (ln == stop_line && h == stop_h) return;
        act = (h >= HST) && (h < HST + HA) && (ln >= VST) && (ln < VST + VA);
        rgb = act ? colour(h - HST, ln - VST) : 12'($urandom);
        drive_cycle(h < HS, ln < VS, rgb);
        if (h == 0 && ln == 0) last_vs_cyc = cyc;
        if (h == 0 && stretch >= 0 && ln == stretch + 1) str_edge_cyc = cyc;
        if (act && ln <= valid_upto) begin
          p.x   = 11'(h - HST);
          p.y   = 10'(ln - VST);
          p.rgb = rgb;
          p.cyc = 24'(cyc + 3);
          exp_q.push_back(p);
        end
      end
    end
  endtask

  task automatic frame(input bit valid);
    drive_frame(0, VT, -1, valid ? VT : -1, -1, -1);
  endtask

  task automatic idle(input int n);
    repeat (n) drive_cycle(1'b0, 1'b0, 12'($urandom));
  endtask

  task automatic check_locked_frame(input string tag);
    check_val({tag, "_locked"}, vif.locked, 1);
    check_val({tag, "_lock_time"}, lock_rise_cyc, last_vs_cyc + 3);
    check_val({tag, "_queue_left"}, exp_q.size(), 0);
    check_val({tag, "_valid_beats"}, valid_cnt, HA * VA);
    check_val({tag, "_last_xy"}, {last_beat.x, last_beat.y}, {11'(HA - 1), 10'(VA - 1)});
    check_val({tag, "_line_len"}, vif.line_len, HT);
    check_val({tag, "_frame_lines"}, vif.frame_lines, VT);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vif.hsync_in = 1'b1;
    vif.vsync_in = 1'b1;
    vif.r_in = '0; vif.g_in = '0; vif.b_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_outputs", all_outs(), 64'd0);
    #5 rst_n = 1'b1;

    // acquire from mid-frame: partial, two unlocked frames, then locked frame
    drive_frame(5, VT, -1, -1, -1, -1);
    frame(1'b0);
    frame(1'b0);
    check_val("prelock_locked", vif.locked, 0);
    valid_cnt = 0;
    frame(1'b1);
    check_locked_frame("acquire");
    check_val("acquire_no_err", err_cnt, 0);

    // one stretched line while locked
    valid_cnt = 0;
    drive_frame(0, VT, STR_LINE, STR_LINE, -1, -1);
    check_val("stretch_err_cnt", err_cnt, 1);
    check_val("stretch_err_time", err_cyc, str_edge_cyc + 3);
    check_val("stretch_line_len", err_line_len, HT + 1);
    check_val("stretch_locked_at_err", err_locked, 0);
    check_val("stretch_valid_beats", valid_cnt, HA * (STR_LINE - VST + 1));
    check_val("stretch_queue_left", exp_q.size(), 0);
    frame(1'b0);
    frame(1'b0);
    valid_cnt = 0;
    frame(1'b1);
    check_locked_frame("stretch_relock");
    check_val("stretch_single_err", err_cnt, 1);

    // hsync removed while locked
    err_cnt = 0;
    idle(2300);
    check_val("timeout_err_cnt", err_cnt, 1);
    check_val("timeout_locked", vif.locked, 0);
    check_val("timeout_hcnt_sat", dut.hcnt_q, 2047);

    // resume, then a short frame while in CHECK
    err_cnt = 0;
    frame(1'b0);
    drive_frame(0, VT - 1, -1, -1, -1, -1);
    frame(1'b0);
    check_val("short_err_cnt", err_cnt, 1);
    check_val("short_frame_lines", err_frame_lines, VT - 1);
    check_val("short_frame_lines_out", vif.frame_lines, VT - 1);
    check_val("short_locked_g", vif.locked, 0);
    frame(1'b0);
    check_val("short_locked_h", vif.locked, 0);
    frame(1'b0);
    check_val("short_locked_i", vif.locked, 0);
    valid_cnt = 0;
    frame(1'b1);
    check_locked_frame("short_relock");
    check_val("short_single_err", err_cnt, 1);

    // reset pulsed mid active line while locked
    drive_frame(0, VT, -1, VT, VST + 1, HST + 5);
    check_val("prereset_locked", vif.locked, 1);
    #5 rst_n = 1'b0;
    #1;
    check_val("async_reset_outputs", all_outs(), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #7 rst_n = 1'b1;
    err_cnt = 0;
    drive_frame(4, VT, -1, -1, -1, -1);
    frame(1'b0);
    frame(1'b0);
    check_val("postreset_prelock", vif.locked, 0);
    valid_cnt = 0;
    frame(1'b1);
    check_locked_frame("postreset");
    check_val("postreset_no_err", err_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_sync_receiver.md
Name: vga_sync_receiver

Overview:
- Receive end of the 640x480@60 VGA pixel interface.
- Samples hsync/vsync/RGB on the 25 MHz pixel clock and rebuilds the horizontal and vertical pixel coordinates.
- Checks line and frame timing against nominal values and outputs a lock flag plus coordinate-tagged pixels.
- Used as a loopback checker for the VGA controller and as the front end for on-board frame capture.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_SYNC, 96, hsync pulse width in clocks
- H_BP, 48, horizontal back porch in clocks
- H_TOTAL, 800, clocks per line
- V_ACTIVE, 480, visible lines per frame
- V_SYNC, 2, vsync pulse width in lines
- V_BP, 33, vertical back porch in lines
- V_TOTAL, 525, lines per frame
- SYNC_ACTIVE_LOW, 1, 1 = syncs are asserted low
- LOCK_FRAMES, 2, consecutive good frames required to assert lock

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- hsync_in  in  1  received hsync
- vsync_in  in  1  received vsync
- r_in, g_in, b_in  in  4 each  received colour
- pix_valid  out  1  r/g/b_out is an active pixel at h_pos/v_pos
- h_pos  out  11  active-area x, 0..639
- v_pos  out  10  active-area y, 0..479
- r_out, g_out, b_out  out  4 each  registered colour
- line_len  out  11  last measured line length in clocks
- frame_lines  out  10  last measured frame length in lines
- locked  out  1  timing lock
- err_pulse  out  1  one-cycle timing violation strobe

Behaviour:
- Reset: every output, counter and pipeline flop is 0; FSM is in SEARCH.
- Input stage: all inputs pass through 2 register stages.
  - "Asserted" means stage-2 level equals the active polarity.
  - An assertion edge is stage 2 asserted while stage 3 (the previous value) was not.
- hcnt (11 bit):
  - Becomes 0 in the cycle an hsync edge is seen; otherwise increments.
  - Saturates at 2047, which is a timeout.
- vcnt (10 bit):
  - Becomes 0 on a vsync edge; otherwise increments on each hsync edge.
  - Saturates at 1023.
  - On simultaneous hsync and vsync edges, vsync wins: vcnt becomes 0.
- On an hsync edge: line_len <= hcnt+1.
- On a vsync edge: frame_lines <= vcnt+1.
- Active window:
  - Horizontal: hcnt in [H_SYNC+H_BP, +H_ACTIVE), i.e. 144..783.
  - Vertical: vcnt in [V_SYNC+V_BP, +V_ACTIVE), i.e. 35..514.
  - h_pos = hcnt-144; v_pos = vcnt-35.
- Output register:
  - pix_valid = locked AND in window.
  - r/g/b_out are the stage-2 colour.
  - Total latency is 3 clocks from input pin to outputs.
  - When pix_valid=0, h_pos, v_pos and colour outputs are forced to 0.
- bad_line flag:
  - Set by any hsync edge with hcnt+1 != H_TOTAL.
  - Cleared on each vsync edge, after that edge's frame evaluation.
- A frame is good when, at a vsync edge, vcnt+1 == V_TOTAL and bad_line == 0.
- FSM states:
  - SEARCH: locked=0. On a vsync edge go to CHECK with good_cnt=0. The partial frame before that edge is discarded.
  - CHECK: on each vsync edge, a good frame does good_cnt++; when good_cnt reaches LOCK_FRAMES go to LOCKED. A bad frame or a timeout goes to SEARCH with err_pulse=1.
  - LOCKED: locked=1. Any bad hsync-edge line, bad frame or timeout goes to SEARCH with err_pulse=1. locked drops on the next clock. Pixels from the offending line after the error are not flagged valid.
- err_pulse is high for exactly one cycle per violation, and never while in SEARCH.
- Reset mid-frame: everything clears asynchronously; relock needs a vsync edge plus LOCK_FRAMES good frames.

Decomposition:
- Shared package vga_timing_pkg: 640x480 timing constants (same values the VGA controller uses), the FSM state encoding (SEARCH/CHECK/LOCKED), and the window start constants 144 and 35.
- Sub-module vga_sync_edge: 2-stage sampler plus polarity normalisation plus assertion-edge detector. Instantiated once for hsync and once for vsync; the colour path uses plain registers.

Test Plan:
- Nominal 640x480 source, 800x525 timing, starting mid-frame:
  - locked rises 1 clk after the 3rd vsync edge reaches stage 2.
  - line_len=800, frame_lines=525.
  - No err_pulse.
- Locked, source pixel (0,0)=F/7/1 and (639,479)=F/1/1:
  - pix_valid with h_pos=0, v_pos=0, RGB=F/7/1 appears 3 clks after that pixel is driven.
  - Last valid beat is h_pos=639, v_pos=479; 640 valid beats per active line.
- Locked, one line stretched to 801 clocks:
  - err_pulse for 1 clk at that hsync edge, locked=0 next clk, line_len=801.
  - Relock after 2 further good frames.
- Locked, hsync removed:
  - hcnt saturates at 2047, err_pulse once, locked=0.
  - No further err_pulse while in SEARCH.
- Frame of 524 lines during CHECK: err_pulse, frame_lines=524, return to SEARCH, locked stays 0.
- rst_n pulsed low mid-active line while locked:
  - All outputs 0 immediately, asynchronously.
  - After release, relock follows the same 3-vsync-edge sequence.
